// File: rtl/pmem_line_adapter.sv
// rtl/pmem_line_adapter.sv - 128-bit wishbone line to 4x32-bit narrow memory beat adapter
// Reads reassemble four beats into DAT_S; writes skip beats whose byte-enable nibble is zero.
module pmem_line_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic         CYC,
  input  logic         STB,
  input  logic         WE,
  input  logic [11:0]  ADR,
  input  logic [15:0]  SEL,
  input  logic [127:0] DAT_M,
  output logic [127:0] DAT_S,
  output logic         ACK,
  output logic         mem_read,
  output logic         mem_write,
  output logic [15:0]  mem_address,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_byte_en,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_resp
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic [11:0]    adr_q, adr_d;
  logic [15:0]    sel_q, sel_d;
  logic [127:0]   line_q, line_d;
  logic [127:0]   rbuf_q, rbuf_d;

  logic [3:0]     nz_in, nz_q;
  logic [2:0]     first_in, next_q;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [2:0] lowest_set(input logic [3:0] v);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      nz_in[k] = |SEL[4*k +: 4];
      nz_q[k]  = |sel_q[4*k +: 4];
    end
    first_in = lowest_set(nz_in);
    next_q   = lowest_set(nz_q & (4'b1110 << beat_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= 2'd0;
      adr_q   <= 12'd0;
      sel_q   <= 16'd0;
      line_q  <= 128'd0;
      rbuf_q  <= 128'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      line_q  <= line_d;
      rbuf_q  <= rbuf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    line_d  = line_q;
    rbuf_d  = rbuf_q;
    case (state_q)
      S_IDLE: begin
        if (CYC && STB) begin
          adr_d  = ADR;
          sel_d  = SEL;
          line_d = DAT_M;
          if (!WE) begin
            beat_d  = 2'd0;
            state_d = S_READ;
          end else if (first_in[2]) begin
            beat_d  = first_in[1:0];
            state_d = S_WRITE;
          end else begin
            beat_d  = 2'd0;
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        if (mem_resp) begin
          rbuf_d[{beat_q, 5'b00000} +: 32] = mem_rdata;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = S_DONE;
        end
      end
      S_WRITE: begin
        if (mem_resp) begin
          if (next_q[2]) beat_d = next_q[1:0];
          else           state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_read    = (state_q == S_READ);
    mem_write   = (state_q == S_WRITE);
    mem_address = 16'd0;
    mem_wdata   = 32'd0;
    mem_byte_en = 4'd0;
    if (state_q == S_READ || state_q == S_WRITE)
      mem_address = {adr_q, beat_q, 2'b00};
    if (state_q == S_WRITE) begin
      mem_wdata   = line_q[{beat_q, 5'b00000} +: 32];
      mem_byte_en = sel_q[{beat_q, 2'b00} +: 4];
    end
    // ACK follows CYC so a master that abandoned the cycle never sees it.
    ACK   = (state_q == S_DONE) && CYC;
    DAT_S = rbuf_q;
  end

endmodule

// File: tb/tb_pmem_line_adapter.sv
// tb/tb_pmem_line_adapter.sv - randomized self-checking bench for pmem_line_adapter
// A queue of expected beats per request models the memory traffic; DAT_S is tracked separately.
module tb_pmem_line_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         CYC, STB, WE;
  logic [11:0]  ADR;
  logic [15:0]  SEL;
  logic [127:0] DAT_M;
  logic [127:0] DAT_S;
  logic         ACK;
  logic         mem_read, mem_write;
  logic [15:0]  mem_address;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_byte_en;
  logic [31:0]  mem_rdata;
  logic         mem_resp;

  int tests_run = 0;
  int tests_failed = 0;
  logic [127:0] model_rbuf = 128'd0;

  pmem_line_adapter dut (
    .clk(clk), .rst(rst), .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR), .SEL(SEL),
    .DAT_M(DAT_M), .DAT_S(DAT_S), .ACK(ACK), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // waits < 0 picks a random 0..3 wait per beat; ack_at < 0 uses the computed latency.
  task automatic do_txn(input string name, input logic we, input logic [11:0] adr,
                        input logic [15:0] sel, input logic [127:0] dat, input int waits,
                        input bit fixed_rd, input bit drop_cyc, input int ack_at);
    int q[$];
    int cyc, wcnt, cur_w, exp_ack, b;
    bit cyc_on, timed_out;
    logic [31:0] rd;
    logic [127:0] exp_line;
    logic [3:0] nib;
    if (!we) begin
      for (int k = 0; k < 4; k++) q.push_back(k);
    end else begin
      for (int k = 0; k < 4; k++) begin
        nib = sel[4*k +: 4];
        if (nib != 4'd0) q.push_back(k);
      end
    end
    exp_line = model_rbuf;
    CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; SEL = sel; DAT_M = dat;
    tick();
    cyc = 1;
    STB = 1'b0;
    ADR = 12'($urandom); SEL = 16'($urandom); WE = 1'($urandom);
    DAT_M = {$urandom, $urandom, $urandom, $urandom};
    cur_w = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
    wcnt = 0; exp_ack = 1; cyc_on = 1'b1; timed_out = 1'b0;
    while (q.size() > 0) begin
      if (cyc > 100) begin
        tests_run++; tests_failed++;
        $display("FAIL %s timeout: %0d beats still pending", name, q.size());
        timed_out = 1'b1;
        break;
      end
      b = q[0];
      tests_run++;
      if ({ACK, mem_read, mem_write} !== {1'b0, !we, we}) begin
        tests_failed++;
        $display("FAIL %s req cyc%0d: ack/rd/wr=%b expected %b", name, cyc,
                 {ACK, mem_read, mem_write}, {1'b0, !we, we});
      end
      tests_run++;
      if (mem_address !== {adr, 2'(b), 2'b00}) begin
        tests_failed++;
        $display("FAIL %s addr cyc%0d: got %h expected %h", name, cyc, mem_address,
                 {adr, 2'(b), 2'b00});
      end
      if (we) begin
        tests_run++;
        if (mem_wdata !== dat[32*b +: 32] || mem_byte_en !== sel[4*b +: 4]) begin
          tests_failed++;
          $display("FAIL %s wdata/be beat%0d: got %h/%h expected %h/%h", name, b,
                   mem_wdata, mem_byte_en, dat[32*b +: 32], sel[4*b +: 4]);
        end
      end
      if (drop_cyc && b == 1) begin
        CYC = 1'b0; cyc_on = 1'b0;
      end
      if (wcnt < cur_w) begin
        mem_resp = 1'b0; mem_rdata = $urandom; wcnt++;
      end else begin
        rd = fixed_rd ? 32'h11111111 * (b + 1) : $urandom;
        mem_resp = 1'b1; mem_rdata = rd;
        if (!we) exp_line[32*b +: 32] = rd;
        void'(q.pop_front());
        exp_ack += cur_w + 1;
        wcnt = 0;
        cur_w = (waits < 0) ? int'($urandom_range(0, 3)) : waits;
      end
      tick();
      cyc++;
    end
    // Responses seen in DONE must be ignored.
    mem_resp = 1'($urandom); mem_rdata = $urandom;
    if (!timed_out) begin
      if (ack_at >= 0) exp_ack = ack_at;
      tests_run++;
      if (cyc != exp_ack || ACK !== cyc_on || {mem_read, mem_write} !== 2'b00) begin
        tests_failed++;
        $display("FAIL %s done: cycle %0d ack %b rdwr %b expected cycle %0d ack %b rdwr 00",
                 name, cyc, ACK, {mem_read, mem_write}, exp_ack, cyc_on);
      end
    end
    tick();
    tests_run++;
    if (ACK !== 1'b0 || {mem_read, mem_write} !== 2'b00) begin
      tests_failed++;
      $display("FAIL %s post-done: ack %b rdwr %b expected 0 00", name, ACK, {mem_read, mem_write});
    end
    mem_resp = 1'b0; CYC = 1'b0;
    if (!we) model_rbuf = exp_line;
    tests_run++;
    if (DAT_S !== model_rbuf) begin
      tests_failed++;
      $display("FAIL %s dat_s: got %h expected %h", name, DAT_S, model_rbuf);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; CYC = 1'b0; STB = 1'b0; WE = 1'b0; ADR = '0; SEL = '0; DAT_M = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    tick(); tick();
    tests_run++;
    if ({DAT_S, ACK, mem_read, mem_write, mem_address, mem_wdata, mem_byte_en} !== '0) begin
      tests_failed++;
      $display("FAIL reset outputs: dat_s %h ack %b rd %b wr %b addr %h wd %h be %h expected all 0",
               DAT_S, ACK, mem_read, mem_write, mem_address, mem_wdata, mem_byte_en);
    end
    rst = 1'b0;
    model_rbuf = 128'd0;
    tick();
  endtask

  task automatic test_read_zero_wait();
    do_txn("read0", 1'b0, 12'h0A3, 16'hFFFF, 128'd0, 0, 1'b1, 1'b0, 5);
    tests_run++;
    if (DAT_S !== 128'h44444444_33333333_22222222_11111111) begin
      tests_failed++;
      $display("FAIL read0 line: got %h expected 44444444333333332222222211111111", DAT_S);
    end
  endtask

  task automatic test_write_waits();
    do_txn("write_wait2", 1'b1, 12'h5C1, 16'hFFFF,
           128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 2, 1'b0, 1'b0, 13);
  endtask

  task automatic test_sparse_write();
    do_txn("sparse_f00f", 1'b1, 12'h123, 16'hF00F, {$urandom, $urandom, $urandom, $urandom},
           0, 1'b0, 1'b0, 3);
    do_txn("sel_zero", 1'b1, 12'h321, 16'h0000, {$urandom, $urandom, $urandom, $urandom},
           0, 1'b0, 1'b0, 1);
  endtask

  task automatic test_cyc_drop();
    do_txn("cyc_drop", 1'b0, 12'hFFF, 16'h0, 128'd0, 0, 1'b0, 1'b1, 5);
    do_txn("after_drop", 1'b0, 12'h001, 16'h0, 128'd0, 0, 1'b0, 1'b0, 5);
  endtask

  task automatic test_reset_mid_write();
    CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = 12'h777; SEL = 16'hFFFF;
    DAT_M = {$urandom, $urandom, $urandom, $urandom};
    tick();
    STB = 1'b0; mem_resp = 1'b1;
    tick(); tick();
    tests_run++;
    if (mem_write !== 1'b1 || mem_address !== 16'h7778) begin
      tests_failed++;
      $display("FAIL rst_mid beat2: wr %b addr %h expected 1 7778", mem_write, mem_address);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if ({DAT_S, ACK, mem_read, mem_write, mem_address, mem_wdata, mem_byte_en} !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid outputs: ack %b rd %b wr %b addr %h wd %h be %h expected all 0",
               ACK, mem_read, mem_write, mem_address, mem_wdata, mem_byte_en);
    end
    rst = 1'b0; mem_resp = 1'b0; CYC = 1'b0;
    model_rbuf = 128'd0;
    tick();
    do_txn("read_after_rst", 1'b0, 12'h0B0, 16'h0, 128'd0, 0, 1'b0, 1'b0, 5);
  endtask

  task automatic test_random();
    logic        we;
    logic [15:0] sel;
    for (int n = 0; n < 30; n++) begin
      we = 1'($urandom);
      sel = 16'($urandom);
      if ($urandom_range(0, 7) == 0) sel = 16'h0;
      else if ($urandom_range(0, 3) == 0) sel = sel & 16'h0F0F;
      do_txn("random", we, 12'($urandom), sel, {$urandom, $urandom, $urandom, $urandom},
             -1, 1'b0, ($urandom_range(0, 9) == 0) && !we, -1);
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_waits();
    test_sparse_write();
    test_cyc_drop();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
